// File: rtl/jstk_pkg.sv
// Shared types and constants for the joystick SPI responder: FSM states,
// byte-index names and the transmit byte selector.
package jstk_pkg;

  localparam int         NUM_BYTES_DEF  = 5;
  localparam logic [5:0] LED_CMD_PREFIX = 6'b100000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    OVER  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    BYTE_X_LO = 3'd0,
    BYTE_X_HI = 3'd1,
    BYTE_Y_LO = 3'd2,
    BYTE_Y_HI = 3'd3,
    BYTE_BTN  = 3'd4
  } byte_idx_e;

  // Byte returned to the master at position idx of the frame.
  function automatic logic [7:0] tx_byte(input logic [2:0] idx, input logic [9:0] x,
                                         input logic [9:0] y, input logic [2:0] btn);
    logic [7:0] b;
    case (byte_idx_e'(idx))
      BYTE_X_LO: b = x[7:0];
      BYTE_X_HI: b = {6'b000000, x[9:8]};
      BYTE_Y_LO: b = y[7:0];
      BYTE_Y_HI: b = {6'b000000, y[9:8]};
      BYTE_BTN:  b = {5'b00000, btn};
      default:   b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer for one SPI pin with registered rise/fall pulses.
// Pulses appear STAGES+1 clocks after the pin changes.
module spi_edge_sync #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_r;
  logic              prev_r;
  logic              rise_r;
  logic              fall_r;

  // Synchronizer chain, one-clock history and edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain_r <= {STAGES{INIT}};
      prev_r  <= INIT;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      chain_r <= {chain_r[STAGES-2:0], din};
      prev_r  <= chain_r[STAGES-1];
      rise_r  <= chain_r[STAGES-1] & ~prev_r;
      fall_r  <= ~chain_r[STAGES-1] & prev_r;
    end
  end

  assign rise = rise_r;
  assign fall = fall_r;

endmodule

// File: rtl/jstk_spi_responder.sv
// SPI mode-0 slave answering the 5-byte joystick frame with X/Y/buttons and
// capturing the LED command. Define JSTK_STATS_EN to add frame/error counters.
module jstk_spi_responder
  import jstk_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_BYTES   = NUM_BYTES_DEF,
  parameter int POS_W       = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SS,
  input  logic             SCLK,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [POS_W-1:0] x_pos,
  input  logic [POS_W-1:0] y_pos,
  input  logic [2:0]       buttons,
  output logic [1:0]       led_out,
  output logic             frame_done,
  output logic             frame_err
`ifdef JSTK_STATS_EN
  ,
  output logic [15:0]      frame_cnt,
  output logic [7:0]       err_cnt
`endif
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_BYTES - 1);
  localparam logic [2:0] FULL_IDX = 3'(NUM_BYTES);
  localparam int         SETTLE_W = SYNC_STAGES + 3;

  logic               ss_rise_s, ss_fall_s, sclk_rise_s, sclk_fall_s;
  logic [SYNC_STAGES:0] mosi_r;
  logic               mosi_s;
  state_e             state_r, state_nx_s;
  logic               start_s, stop_s, bit_rise_s, bit_fall_s, extra_s;
  logic [SETTLE_W-1:0] settle_r;
  logic               ss_hi_r, armed_r;
  logic [POS_W-1:0]   x_snap_r, y_snap_r;
  logic [2:0]         btn_snap_r;
  logic [2:0]         byte_idx_r, bit_cnt_r;
  logic               byte_done_r, extra_r;
  logic [6:0]         rx_r, tx_r;
  logic [7:0]         rx_nx_s, tx0_s, txn_s;
  logic               miso_r, done_r, err_r;
  logic [1:0]         led_r;

  spi_edge_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_ss_sync (
    .clk(clk), .rst(rst), .din(SS), .rise(ss_rise_s), .fall(ss_fall_s)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(SCLK), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );

  // MOSI synchronizer, one flop deeper so it lines up with the SCLK pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mosi_r <= '0;
    else      mosi_r <= {mosi_r[SYNC_STAGES-1:0], MOSI};
  end

  assign mosi_s  = mosi_r[SYNC_STAGES];
  assign rx_nx_s = {rx_r, mosi_s};
  assign tx0_s   = tx_byte(3'd0, x_pos[9:0], y_pos[9:0], buttons);
  assign txn_s   = tx_byte(byte_idx_r, x_snap_r[9:0], y_snap_r[9:0], btn_snap_r);

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_nx_s;
  end

  // Next state and per-cycle action decode; ss_rise has priority over SCLK.
  always_comb begin
    state_nx_s = state_r;
    start_s    = 1'b0;
    stop_s     = 1'b0;
    bit_rise_s = 1'b0;
    bit_fall_s = 1'b0;
    extra_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (ss_fall_s && armed_r) begin
          start_s    = 1'b1;
          state_nx_s = SHIFT;
        end else begin
          state_nx_s = IDLE;
        end
      end
      SHIFT: begin
        if (ss_rise_s) begin
          stop_s     = 1'b1;
          state_nx_s = IDLE;
        end else if (sclk_rise_s) begin
          bit_rise_s = 1'b1;
          if (bit_cnt_r == 3'd7 && byte_idx_r == LAST_IDX) state_nx_s = OVER;
          else                                             state_nx_s = SHIFT;
        end else if (sclk_fall_s) begin
          bit_fall_s = 1'b1;
        end else begin
          state_nx_s = SHIFT;
        end
      end
      OVER: begin
        if (ss_rise_s) begin
          stop_s     = 1'b1;
          state_nx_s = IDLE;
        end else if (sclk_rise_s) begin
          extra_s = 1'b1;
        end else begin
          state_nx_s = OVER;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // SS must be seen high once the synchronizers hold real pin samples before a
  // frame may start, so a reset released mid-frame never joins that frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      settle_r <= '0;
      ss_hi_r  <= 1'b1;
      armed_r  <= 1'b0;
    end else begin
      settle_r <= {settle_r[SETTLE_W-2:0], 1'b1};
      if (ss_fall_s)      ss_hi_r <= 1'b0;
      else if (ss_rise_s) ss_hi_r <= 1'b1;
      armed_r <= armed_r | (settle_r[SETTLE_W-1] & ss_hi_r);
    end
  end

  // Frame datapath: snapshot, shift registers, LED capture and end-of-frame pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_snap_r    <= '0;
      y_snap_r    <= '0;
      btn_snap_r  <= 3'b000;
      byte_idx_r  <= 3'd0;
      bit_cnt_r   <= 3'd0;
      byte_done_r <= 1'b0;
      extra_r     <= 1'b0;
      rx_r        <= 7'd0;
      tx_r        <= 7'd0;
      miso_r      <= 1'b0;
      led_r       <= 2'b00;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      if (start_s) begin
        x_snap_r    <= x_pos;
        y_snap_r    <= y_pos;
        btn_snap_r  <= buttons;
        byte_idx_r  <= 3'd0;
        bit_cnt_r   <= 3'd0;
        byte_done_r <= 1'b0;
        extra_r     <= 1'b0;
        rx_r        <= 7'd0;
        tx_r        <= tx0_s[6:0];
        miso_r      <= tx0_s[7];
      end else if (stop_s) begin
        miso_r <= 1'b0;
        if (byte_idx_r == FULL_IDX && bit_cnt_r == 3'd0 && !extra_r) done_r <= 1'b1;
        else                                                         err_r  <= 1'b1;
      end else if (bit_rise_s) begin
        rx_r      <= rx_nx_s[6:0];
        bit_cnt_r <= bit_cnt_r + 3'd1;
        if (bit_cnt_r == 3'd7) begin
          byte_done_r <= 1'b1;
          byte_idx_r  <= byte_idx_r + 3'd1;
          if (byte_idx_r == 3'd0 && rx_nx_s[7:2] == LED_CMD_PREFIX) led_r <= rx_nx_s[1:0];
          if (byte_idx_r == LAST_IDX) miso_r <= 1'b0;
        end
      end else if (bit_fall_s) begin
        if (byte_done_r) begin
          byte_done_r <= 1'b0;
          tx_r        <= txn_s[6:0];
          miso_r      <= txn_s[7];
        end else begin
          tx_r   <= {tx_r[5:0], 1'b0};
          miso_r <= tx_r[6];
        end
      end else if (extra_s) begin
        extra_r <= 1'b1;
      end
    end
  end

  assign MISO       = miso_r;
  assign led_out    = led_r;
  assign frame_done = done_r;
  assign frame_err  = err_r;

`ifdef JSTK_STATS_EN
  logic [15:0] frame_cnt_r;
  logic [7:0]  err_cnt_r;

  // Saturating frame and error counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_r <= 16'd0;
      err_cnt_r   <= 8'd0;
    end else begin
      if (done_r && frame_cnt_r != 16'hFFFF) frame_cnt_r <= frame_cnt_r + 16'd1;
      if (err_r && err_cnt_r != 8'hFF)       err_cnt_r   <= err_cnt_r + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_r;
  assign err_cnt   = err_cnt_r;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Directed bench for jstk_spi_responder: acts as the SPI master, scoreboards
// returned MISO bytes and counts frame_done/frame_err pulses.
module tb_jstk_spi_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       SS, SCLK, MOSI;
  logic       MISO;
  logic [9:0] x_pos, y_pos;
  logic [2:0] buttons;
  logic [1:0] led_out;
  logic       frame_done, frame_err;
`ifdef JSTK_STATS_EN
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
`endif

  jstk_spi_responder dut (
    .clk(clk), .rst(rst), .SS(SS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .x_pos(x_pos), .y_pos(y_pos), .buttons(buttons), .led_out(led_out),
    .frame_done(frame_done), .frame_err(frame_err)
`ifdef JSTK_STATS_EN
    , .frame_cnt(frame_cnt), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int done_hi = 0, err_hi = 0, both_hi = 0;
  int d_base = 0, e_base = 0;
  int exp_fc = 0, exp_ec = 0;
  logic [7:0] sb_q[$];

  // Pulse monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (frame_done) done_hi++;
    if (frame_err) err_hi++;
    if (frame_done && frame_err) both_hi++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int i, input logic [9:0] x, input logic [9:0] y,
                                          input logic [2:0] b);
    case (i)
      0: return x[7:0];
      1: return {6'b000000, x[9:8]};
      2: return y[7:0];
      3: return {6'b000000, y[9:8]};
      4: return {5'b00000, b};
      default: return 8'h00;
    endcase
  endfunction

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      MOSI = tx[i];
      clks(8);
      rx[i] = MISO;
      SCLK = 1'b1;
      clks(8);
      SCLK = 1'b0;
    end
  endtask

  task automatic run_frame(input int n, input logic [7:0] c0, input int chg_at,
                           input logic [9:0] nx, input logic [9:0] ny, input logic [2:0] nb);
    logic [7:0] rx, exp;
    d_base = done_hi;
    e_base = err_hi;
    for (int i = 0; i < n; i++) sb_q.push_back(exp_byte(i, x_pos, y_pos, buttons));
    SS = 1'b0;
    clks(16);
    for (int i = 0; i < n; i++) begin
      spi_byte((i == 0) ? c0 : 8'h00, rx);
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
      check($sformatf("miso_byte%0d", i), {24'd0, rx}, {24'd0, exp});
      if (i == chg_at) begin
        x_pos = nx;
        y_pos = ny;
        buttons = nb;
      end
    end
    clks(8);
    SS = 1'b1;
    clks(12);
  endtask

  task automatic pulses(input string tag, input int exp_d, input int exp_e);
    exp_fc += exp_d;
    exp_ec += exp_e;
    check({tag, "_done"}, done_hi - d_base, exp_d);
    check({tag, "_err"}, err_hi - e_base, exp_e);
    check({tag, "_both"}, both_hi, 0);
    check({tag, "_miso_idle"}, {31'd0, MISO}, 32'd0);
`ifdef JSTK_STATS_EN
    check({tag, "_frame_cnt"}, {16'd0, frame_cnt}, exp_fc);
    check({tag, "_err_cnt"}, {24'd0, err_cnt}, exp_ec);
`endif
  endtask

  initial begin
    logic [7:0] rx;
    rst = 1'b0; SS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    x_pos = 10'h000; y_pos = 10'h000; buttons = 3'b000;
    clks(4);
    check("rst_miso", {31'd0, MISO}, 32'd0);
    check("rst_led", {30'd0, led_out}, 32'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    check("rst_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b1;
    clks(10);

    // Valid LED command, full frame.
    x_pos = 10'h2A5; y_pos = 10'h13C; buttons = 3'b101;
    run_frame(5, 8'h81, -1, 10'h0, 10'h0, 3'b000);
    check("f1_led", {30'd0, led_out}, 32'd1);
    pulses("f1", 1, 0);

    // Bad prefix leaves LED alone.
    x_pos = 10'h155; y_pos = 10'h2C3; buttons = 3'b010;
    run_frame(5, 8'h7F, -1, 10'h0, 10'h0, 3'b000);
    check("f2_led", {30'd0, led_out}, 32'd1);
    pulses("f2", 1, 0);

    // Short frame, then a good one.
    x_pos = 10'h3FF; y_pos = 10'h000; buttons = 3'b111;
    run_frame(3, 8'h00, -1, 10'h0, 10'h0, 3'b000);
    pulses("short", 0, 1);
    x_pos = 10'h001; y_pos = 10'h3FE; buttons = 3'b000;
    run_frame(5, 8'h82, -1, 10'h0, 10'h0, 3'b000);
    check("f4_led", {30'd0, led_out}, 32'd2);
    pulses("f4", 1, 0);

    // Long frame: sixth byte reads zero.
    x_pos = 10'h2A5; y_pos = 10'h13C; buttons = 3'b101;
    run_frame(6, 8'h00, -1, 10'h0, 10'h0, 3'b000);
    check("long_led", {30'd0, led_out}, 32'd2);
    pulses("long", 0, 1);

    // Inputs changed after byte 1 must not alter the frame; next frame sees them.
    x_pos = 10'h123; y_pos = 10'h321; buttons = 3'b110;
    run_frame(5, 8'h83, 1, 10'h3FF, 10'h2AA, 3'b001);
    check("snap_led", {30'd0, led_out}, 32'd3);
    pulses("snap", 1, 0);
    run_frame(5, 8'h80, -1, 10'h0, 10'h0, 3'b000);
    check("post_led", {30'd0, led_out}, 32'd0);
    pulses("post", 1, 0);

    // Reset mid-frame, released with SS still low.
    x_pos = 10'h0FF; y_pos = 10'h0FF; buttons = 3'b111;
    SS = 1'b0;
    clks(16);
    spi_byte(8'h81, rx);
    MOSI = 1'b1;
    clks(8);
    SCLK = 1'b1;
    clks(3);
    rst = 1'b0;
    #1;
    check("midrst_miso", {31'd0, MISO}, 32'd0);
    check("midrst_led", {30'd0, led_out}, 32'd0);
    exp_fc = 0;
    exp_ec = 0;
    clks(5);
    SCLK = 1'b0;
    rst = 1'b1;
    clks(10);
    d_base = done_hi;
    e_base = err_hi;
    spi_byte(8'h81, rx);
    check("join_miso", {24'd0, rx}, 32'd0);
    check("join_led", {30'd0, led_out}, 32'd0);
    clks(8);
    SS = 1'b1;
    clks(12);
    pulses("join", 0, 0);
    x_pos = 10'h2A5; y_pos = 10'h13C; buttons = 3'b101;
    run_frame(5, 8'h81, -1, 10'h0, 10'h0, 3'b000);
    check("fresh_led", {30'd0, led_out}, 32'd1);
    pulses("fresh", 1, 0);
    check("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
